// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between N requesting masters, the arbiter and one slave.
// Master-side signals are packed per master: master i at [i*W +: W].
interface wb_rr_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [N*AW-1:0]     m_addr;
  logic [N*DW-1:0]     m_wdata;
  logic [N*DW/8-1:0]   m_wmsk;
  logic [N-1:0]        m_we;
  logic [N-1:0]        m_cyc;
  logic [DW-1:0]       m_rdata;
  logic [N-1:0]        m_ack;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic [DW/8-1:0]     s_wmsk;
  logic                s_we;
  logic                s_cyc;
  logic [DW-1:0]       s_rdata;
  logic                s_ack;

  modport arb (
    input  m_addr, m_wdata, m_wmsk, m_we, m_cyc,
    input  s_rdata, s_ack,
    output m_rdata, m_ack,
    output s_addr, s_wdata, s_wmsk, s_we, s_cyc
  );

  modport master (
    output m_addr, m_wdata, m_wmsk, m_we, m_cyc,
    input  m_rdata, m_ack
  );

  modport slave (
    input  s_addr, s_wdata, s_wmsk, s_we, s_cyc,
    output s_rdata, s_ack
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, one transaction
// per grant, with a watchdog that aborts stuck cycles with an error ack.
module wb_rr_arbiter #(
  parameter int N  = 2,
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_rr_arbiter_if.arb  bus,
  output logic [N-1:0]  grant,
  output logic          timeout_err
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (TW > 0) ? TW : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [LW-1:0] last;
  logic [LW-1:0] pick;
  logic [WW-1:0] wdog;
  logic          found;
  logic          busy;
  logic          cyc_g;
  logic          tc;
  logic          to;
  logic          done;

  // Lowest index above last wins; otherwise wrap to lowest at or below it.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.m_cyc[k] && k <= int'(last)) begin
        pick  = LW'(k);
        found = 1'b1;
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.m_cyc[k] && k > int'(last)) begin
        pick  = LW'(k);
        found = 1'b1;
      end
    end
  end

  // While busy, last always holds the granted master's index.
  assign busy  = (state == BUSY);
  assign cyc_g = bus.m_cyc[last];
  assign tc    = (TW > 0) && (&wdog);
  assign to    = busy & cyc_g & tc & ~bus.s_ack;
  assign done  = ~cyc_g | bus.s_ack | tc;

  assign bus.s_addr  = bus.m_addr[int'(last)*AW +: AW];
  assign bus.s_wdata = bus.m_wdata[int'(last)*DW +: DW];
  assign bus.s_wmsk  = bus.m_wmsk[int'(last)*(DW/8) +: DW/8];
  assign bus.s_we    = bus.m_we[last];
  assign bus.s_cyc   = busy & cyc_g & ~to;
  assign bus.m_rdata = to ? {DW{1'b1}} : bus.s_rdata;
  assign timeout_err = to;

  always_comb begin
    bus.m_ack       = '0;
    bus.m_ack[last] = busy & cyc_g & (bus.s_ack | tc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(N - 1);
      wdog  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wdog <= '0;
          if (found) begin
            state <= BUSY;
            grant <= {{(N-1){1'b0}}, 1'b1} << pick;
            last  <= pick;
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            grant <= '0;
            wdog  <= '0;
          end else if (TW > 0 && !tc) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: N=3 masters, 4-bit watchdog.
// Inputs change 1ns after posedge, outputs are checked 2ns after posedge.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TW = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] grant;
  logic         timeout_err;
  int           tests;
  int           fails;

  wb_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .TW(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wmsk  = '0;
    bus.m_we    = '0;
    bus.m_cyc   = '0;
    bus.s_rdata = '0;
    bus.s_ack   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.m_cyc = 3'b111;
    step();
    #1;
    tests++;
    if (grant !== 3'b000) begin
      fails++;
      $display("FAIL reset_grant got %b want 000", grant);
    end
    tests++;
    if (bus.s_cyc !== 1'b0 || bus.m_ack !== 3'b000 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs got cyc=%b ack=%b to=%b want 0 000 0",
               bus.s_cyc, bus.m_ack, timeout_err);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m_cyc = 3'b001;
    #1;
    tests++;
    if (bus.s_cyc !== 1'b0) begin
      fails++;
      $display("FAIL rd_latency got s_cyc=%b want 0", bus.s_cyc);
    end
    step();
    tests++;
    if (grant !== 3'b001 || bus.s_cyc !== 1'b1) begin
      fails++;
      $display("FAIL rd_grant got grant=%b cyc=%b want 001 1", grant, bus.s_cyc);
    end
    step();
    bus.s_ack   = 1'b1;
    bus.s_rdata = 32'hDEADBEEF;
    #1;
    tests++;
    if (bus.m_ack !== 3'b001 || bus.m_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_ack got ack=%b rdata=%h want 001 deadbeef",
               bus.m_ack, bus.m_rdata);
    end
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
    #1;
    tests++;
    if (grant !== 3'b000) begin
      fails++;
      $display("FAIL rd_release got grant=%b want 000", grant);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp [6];
    int n;
    exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    bus.m_cyc = 3'b111;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      while (bus.s_cyc !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      tests++;
      if (grant !== exp[t] || n >= 8) begin
        fails++;
        $display("FAIL rr_grant%0d got %b want %b", t, grant, exp[t]);
      end
      bus.s_ack = 1'b1;
      #1;
      tests++;
      if (bus.m_ack !== exp[t]) begin
        fails++;
        $display("FAIL rr_ack%0d got %b want %b", t, bus.m_ack, exp[t]);
      end
      step();
      bus.s_ack = 1'b0;
    end
    bus.m_cyc = 3'b000;
  endtask

  task automatic test_write_mux();
    do_reset();
    bus.m_addr  = {16'h0000, 16'h0123, 16'hAAAA};
    bus.m_wdata = {32'h0, 32'hCAFEF00D, 32'h11111111};
    bus.m_wmsk  = {4'h0, 4'b0011, 4'b1111};
    bus.m_we    = 3'b010;
    bus.m_cyc   = 3'b010;
    step();
    tests++;
    if (grant !== 3'b010 || bus.s_we !== 1'b1 || bus.s_cyc !== 1'b1) begin
      fails++;
      $display("FAIL wr_ctrl got grant=%b we=%b cyc=%b want 010 1 1",
               grant, bus.s_we, bus.s_cyc);
    end
    tests++;
    if (bus.s_addr !== 16'h0123 || bus.s_wmsk !== 4'b0011 ||
        bus.s_wdata !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL wr_data got a=%h m=%b d=%h want 0123 0011 cafef00d",
               bus.s_addr, bus.s_wmsk, bus.s_wdata);
    end
    bus.s_ack = 1'b1;
    #1;
    tests++;
    if (bus.m_ack !== 3'b010) begin
      fails++;
      $display("FAIL wr_ack got %b want 010", bus.m_ack);
    end
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
  endtask

  task automatic test_watchdog();
    int early;
    do_reset();
    bus.m_cyc   = 3'b001;
    bus.s_rdata = 32'h0BADF00D;
    step();
    early = 0;
    for (int k = 1; k < 15; k++) begin
      if (timeout_err !== 1'b0 || bus.s_cyc !== 1'b1) early++;
      step();
    end
    if (timeout_err !== 1'b0 || bus.s_cyc !== 1'b1) early++;
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL wd_early got %0d bad cycles want 0", early);
    end
    step();
    tests++;
    if (timeout_err !== 1'b1 || bus.m_ack !== 3'b001 || bus.s_cyc !== 1'b0) begin
      fails++;
      $display("FAIL wd_abort got to=%b ack=%b cyc=%b want 1 001 0",
               timeout_err, bus.m_ack, bus.s_cyc);
    end
    tests++;
    if (bus.m_rdata !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL wd_rdata got %h want ffffffff", bus.m_rdata);
    end
    bus.m_cyc = 3'b011;
    step();
    tests++;
    if (timeout_err !== 1'b0 || grant !== 3'b000) begin
      fails++;
      $display("FAIL wd_pulse got to=%b grant=%b want 0 000", timeout_err, grant);
    end
    step();
    tests++;
    if (grant !== 3'b010) begin
      fails++;
      $display("FAIL wd_next got %b want 010", grant);
    end
    bus.s_ack = 1'b1;
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
  endtask

  task automatic test_ack_at_terminal();
    do_reset();
    bus.m_cyc = 3'b001;
    step();
    for (int k = 0; k < 15; k++) step();
    bus.s_ack   = 1'b1;
    bus.s_rdata = 32'h12345678;
    #1;
    tests++;
    if (timeout_err !== 1'b0 || bus.m_ack !== 3'b001) begin
      fails++;
      $display("FAIL tc_ack got to=%b ack=%b want 0 001", timeout_err, bus.m_ack);
    end
    tests++;
    if (bus.m_rdata !== 32'h12345678 || bus.s_cyc !== 1'b1) begin
      fails++;
      $display("FAIL tc_data got rdata=%h cyc=%b want 12345678 1",
               bus.m_rdata, bus.s_cyc);
    end
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
  endtask

  task automatic test_abort_and_reset();
    do_reset();
    bus.m_cyc = 3'b001;
    step();
    bus.m_cyc = 3'b000;
    #1;
    tests++;
    if (bus.s_cyc !== 1'b0 || bus.m_ack !== 3'b000) begin
      fails++;
      $display("FAIL abort_cyc got cyc=%b ack=%b want 0 000", bus.s_cyc, bus.m_ack);
    end
    step();
    tests++;
    if (grant !== 3'b000) begin
      fails++;
      $display("FAIL abort_grant got %b want 000", grant);
    end
    bus.m_cyc = 3'b010;
    step();
    tests++;
    if (grant !== 3'b010 || bus.s_cyc !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre got grant=%b cyc=%b want 010 1", grant, bus.s_cyc);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.s_cyc !== 1'b0 || grant !== 3'b000 || bus.m_ack !== 3'b000) begin
      fails++;
      $display("FAIL midrst_async got cyc=%b grant=%b ack=%b want 0 000 000",
               bus.s_cyc, grant, bus.m_ack);
    end
    step();
    rst_n     = 1'b1;
    bus.m_cyc = 3'b011;
    step();
    tests++;
    if (grant !== 3'b001) begin
      fails++;
      $display("FAIL midrst_first got %b want 001", grant);
    end
    bus.s_ack = 1'b1;
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 3'b000;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    do_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_mux();
    test_watchdog();
    test_ack_at_terminal();
    test_abort_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
